// File: rtl/tracklet_rinv_rescale.sv
// 3-stage signed 18x16 tracklet multiply, round-half-up rescale to rinv, range cut and monitor counters.
// Define RINV_SATURATE_EN to clamp failing results to +/-RINV_MAX instead of wrapping them.
module tracklet_rinv_rescale #(
  parameter int SHIFT    = 20,
  parameter int OUT_W    = 14,
  parameter int RINV_MAX = 3000,
  parameter int TAG_W    = 7
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      din0,
  input  logic [15:0]      din1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] rinv,
  output logic             rinv_pass,
  output logic [TAG_W-1:0] out_tag,
  input  logic             cnt_clr,
  output logic [15:0]      n_pass,
  output logic [15:0]      n_fail
);

  localparam logic signed [34:0] ROUND_C = 35'sd1 <<< (SHIFT - 1);
  localparam logic signed [34:0] MAX_S   = 35'(RINV_MAX);
  localparam logic signed [34:0] MIN_S   = -MAX_S;

  logic                    en;
  logic                    xfer;
  logic                    v1_q, v2_q, v3_q;
  logic signed [17:0]      a_q;
  logic signed [15:0]      b_q;
  logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q;
  logic signed [33:0]      prod_d, prod_q;
  logic signed [34:0]      sum_d, r_d;
  logic [OUT_W-1:0]        rinv_d, rinv_q;
  logic                    pass_d, pass_q;
  logic [15:0]             nPass_d, nPass_q, nFail_d, nFail_q;

  // The whole pipe advances or freezes together, so backpressure reaches in_ready in the same cycle.
  assign en       = !v3_q || out_ready;
  assign in_ready = en;
  assign xfer     = v3_q && out_ready;

  assign prod_d = 34'(a_q) * 34'(b_q);

  always_comb begin
    sum_d  = 35'(prod_q) + ROUND_C;
    r_d    = sum_d >>> SHIFT;
    pass_d = (r_d >= MIN_S) && (r_d <= MAX_S);
    rinv_d = r_d[OUT_W-1:0];
`ifdef RINV_SATURATE_EN
    if (r_d > MAX_S) begin
      rinv_d = MAX_S[OUT_W-1:0];
    end else if (r_d < MIN_S) begin
      rinv_d = MIN_S[OUT_W-1:0];
    end
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      prod_q <= '0;
      rinv_q <= '0;
      pass_q <= 1'b0;
    end else if (en) begin
      v1_q   <= in_valid;
      a_q    <= din0;
      b_q    <= din1;
      tag1_q <= in_tag;
      v2_q   <= v1_q;
      prod_q <= prod_d;
      tag2_q <= tag1_q;
      v3_q   <= v2_q;
      rinv_q <= rinv_d;
      pass_q <= pass_d;
      tag3_q <= tag2_q;
    end
  end

  // A clear coinciding with a transfer wins; the transfer goes uncounted.
  always_comb begin
    nPass_d = nPass_q;
    nFail_d = nFail_q;
    if (cnt_clr) begin
      nPass_d = '0;
      nFail_d = '0;
    end else if (xfer) begin
      if (pass_q) begin
        if (nPass_q != 16'hFFFF) nPass_d = nPass_q + 16'd1;
      end else begin
        if (nFail_q != 16'hFFFF) nFail_d = nFail_q + 16'd1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      nPass_q <= '0;
      nFail_q <= '0;
    end else begin
      nPass_q <= nPass_d;
      nFail_q <= nFail_d;
    end
  end

  assign out_valid = v3_q;
  assign rinv      = rinv_q;
  assign rinv_pass = pass_q;
  assign out_tag   = tag3_q;
  assign n_pass    = nPass_q;
  assign n_fail    = nFail_q;

endmodule

// File: tb/tb_tracklet_rinv_rescale.sv
// Self-checking bench for tracklet_rinv_rescale: directed and random operand pairs against an
// arithmetic reference; honours RINV_SATURATE_EN the same way the design does.
module tb_tracklet_rinv_rescale;

  localparam int SHIFT    = 20;
  localparam int OUT_W    = 14;
  localparam int RINV_MAX = 3000;
  localparam int TAG_W    = 7;

  logic             ap_clk = 1'b0;
  logic             ap_rst, in_valid, in_ready, out_valid, out_ready, rinv_pass, cnt_clr;
  logic [17:0]      din0;
  logic [15:0]      din1;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [OUT_W-1:0] rinv;
  logic [15:0]      n_pass, n_fail;

  typedef struct {
    logic [OUT_W-1:0] rinv;
    logic             pass;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             expQ[$];
  int               checks = 0;
  int               errors = 0;
  int unsigned      mPass = 0;
  int unsigned      mFail = 0;
  bit               holdPending = 0;
  logic [OUT_W-1:0] holdRinv;
  logic             holdPass;
  logic [TAG_W-1:0] holdTag;

  tracklet_rinv_rescale #(
    .SHIFT(SHIFT), .OUT_W(OUT_W), .RINV_MAX(RINV_MAX), .TAG_W(TAG_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .rinv(rinv), .rinv_pass(rinv_pass), .out_tag(out_tag),
    .cnt_clr(cnt_clr), .n_pass(n_pass), .n_fail(n_fail)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Floor division of (product + half) by 2^SHIFT gives round-half-up.
  function automatic longint refR(input logic [17:0] a, input logic [15:0] b);
    longint p, q, d;
    p = longint'($signed(a)) * longint'($signed(b));
    d = longint'(1) << SHIFT;
    q = p + d / 2;
    if (q >= 0) return q / d;
    return -((-q + d - 1) / d);
  endfunction

  function automatic exp_t refEntry(input logic [17:0] a, input logic [15:0] b,
                                    input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint r, v;
    r      = refR(a, b);
    e.pass = (r >= -RINV_MAX) && (r <= RINV_MAX);
    v      = r;
`ifdef RINV_SATURATE_EN
    if (r > RINV_MAX) v = RINV_MAX;
    else if (r < -RINV_MAX) v = -RINV_MAX;
`endif
    e.rinv = v[OUT_W-1:0];
    e.tag  = tag;
    return e;
  endfunction

  // One clock: observe handshakes just before the edge, update the model, check counters after it.
  task automatic applyStimulus(output bit accepted);
    bit   inX, outX, ePass;
    exp_t e;
    #2;
    inX   = in_valid && in_ready;
    outX  = out_valid && out_ready;
    ePass = 1'b0;
    if (holdPending) begin
      checkVal("hold_rinv", rinv, holdRinv);
      checkVal("hold_pass", rinv_pass, holdPass);
      checkVal("hold_tag", out_tag, holdTag);
    end
    if (expQ.size() == 0) checkVal("idle_out_valid", out_valid, 1'b0);
    if (outX && expQ.size() > 0) begin
      e     = expQ.pop_front();
      ePass = e.pass;
      checkVal("rinv", rinv, e.rinv);
      checkVal("rinv_pass", rinv_pass, e.pass);
      checkVal("out_tag", out_tag, e.tag);
    end
    holdPending = out_valid && !out_ready;
    holdRinv    = rinv;
    holdPass    = rinv_pass;
    holdTag     = out_tag;
    if (ap_rst) begin
      expQ.delete();
      mPass       = 0;
      mFail       = 0;
      holdPending = 0;
    end else begin
      if (cnt_clr) begin
        mPass = 0;
        mFail = 0;
      end else if (outX) begin
        if (ePass) begin
          if (mPass != 65535) mPass++;
        end else begin
          if (mFail != 65535) mFail++;
        end
      end
      if (inX) expQ.push_back(refEntry(din0, din1, in_tag));
    end
    accepted = inX && !ap_rst;
    @(posedge ap_clk);
    #1;
    checkVal("n_pass", n_pass, mPass);
    checkVal("n_fail", n_fail, mFail);
  endtask

  task automatic checkOutput(input string name, input logic [OUT_W-1:0] expRinv,
                             input logic expPass, input logic [TAG_W-1:0] expTag);
    checkVal({name, "_valid"}, out_valid, 1'b1);
    checkVal({name, "_rinv"}, rinv, expRinv);
    checkVal({name, "_pass"}, rinv_pass, expPass);
    checkVal({name, "_tag"}, out_tag, expTag);
  endtask

  // Accept one pair and advance until its result is visible (not yet transferred).
  task automatic sendPeek(input logic [17:0] a, input logic [15:0] b, input logic [TAG_W-1:0] tag);
    bit acc;
    in_valid = 1'b1; din0 = a; din1 = b; in_tag = tag;
    applyStimulus(acc);
    checkVal("peek_accept", acc, 1'b1);
    in_valid = 1'b0;
    applyStimulus(acc);
    applyStimulus(acc);
  endtask

  initial begin
    bit               acc;
    int               sent, cyc;
    int unsigned      basePass;
    logic [17:0]      bpA[6];
    logic [15:0]      bpB[6];
    logic [OUT_W-1:0] cutRinv;

    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    din0 = '0; din1 = '0; in_tag = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    checkVal("rst_out_valid", out_valid, 1'b0);
    checkVal("rst_rinv", rinv, '0);
    checkVal("rst_pass", rinv_pass, 1'b0);
    checkVal("rst_tag", out_tag, '0);
    checkVal("rst_n_pass", n_pass, 16'd0);
    checkVal("rst_n_fail", n_fail, 16'd0);
    checkVal("rst_in_ready", in_ready, 1'b1);

    // Latency: accepted at edge N, visible after edge N+2.
    in_valid = 1'b1; din0 = 18'd1024; din1 = 16'd1024; in_tag = 7'd5;
    applyStimulus(acc);
    checkVal("lat_accept", acc, 1'b1);
    in_valid = 1'b0;
    checkVal("lat_n1", out_valid, 1'b0);
    applyStimulus(acc);
    checkVal("lat_n2", out_valid, 1'b0);
    applyStimulus(acc);
    checkOutput("basic", 14'd1, 1'b1, 7'd5);
    applyStimulus(acc);
    checkVal("basic_n_pass", n_pass, 16'd1);

    sendPeek(-18'sd1024, 16'd1024, 7'd6);
    checkOutput("neg_one", 14'h3FFF, 1'b1, 7'd6);
    applyStimulus(acc);
    sendPeek(-18'sd512, 16'd1024, 7'd7);
    checkOutput("neg_half", 14'd0, 1'b1, 7'd7);
    applyStimulus(acc);

`ifdef RINV_SATURATE_EN
    cutRinv = 14'd3000;
`else
    cutRinv = 14'd4096;
`endif
    sendPeek(18'd131071, 16'd32767, 7'd9);
    checkOutput("cut", cutRinv, 1'b0, 7'd9);
    applyStimulus(acc);
    checkVal("cut_n_fail", n_fail, 16'd1);
    checkVal("cut_n_pass", n_pass, 16'd3);

    // Backpressure: six pairs, out_ready low for four cycles mid-stream.
    for (int i = 0; i < 6; i++) begin
      bpA[i] = 18'($signed($urandom_range(2000)) - 1000);
      bpB[i] = 16'($urandom);
    end
    basePass = mPass;
    sent = 0;
    cyc  = 0;
    while (sent < 6 && cyc < 60) begin
      in_valid  = 1'b1;
      din0      = bpA[sent];
      din1      = bpB[sent];
      in_tag    = 7'(sent + 32);
      out_ready = !(cyc >= 3 && cyc < 7);
      #1;
      if (cyc >= 3 && cyc < 7) checkVal("stall_in_ready", in_ready, 1'b0);
      applyStimulus(acc);
      if (acc) sent++;
      cyc++;
    end
    checkVal("bp_sent", sent, 6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) applyStimulus(acc);
    checkVal("bp_drained", expQ.size(), 0);
    checkVal("bp_n_pass", n_pass, basePass + 6);

    // Random traffic with random backpressure, clears and full-range operands.
    for (int i = 0; i < 80; i++) begin
      in_valid  = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0);
      cnt_clr   = ($urandom_range(15) == 0);
      din0      = 18'($urandom);
      din1      = ($urandom_range(1) != 0) ? 16'($urandom) : 16'($urandom_range(255));
      in_tag    = 7'($urandom);
      applyStimulus(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (6) applyStimulus(acc);
    checkVal("rand_drained", expQ.size(), 0);

    // Reset with three entries in flight.
    sendPeek(18'd1024, 16'd1024, 7'd1);
    in_valid = 1'b1; din0 = 18'd2048; din1 = 16'd1024; in_tag = 7'd2;
    applyStimulus(acc);
    in_tag = 7'd3;
    applyStimulus(acc);
    in_valid = 1'b0; out_ready = 1'b0; ap_rst = 1'b1;
    applyStimulus(acc);
    ap_rst = 1'b0;
    checkVal("mid_rst_valid", out_valid, 1'b0);
    checkVal("mid_rst_n_pass", n_pass, 16'd0);
    checkVal("mid_rst_n_fail", n_fail, 16'd0);
    out_ready = 1'b1;
    repeat (5) applyStimulus(acc);
    checkVal("mid_rst_no_stale", out_valid, 1'b0);

    // Saturation: 65535 passing transfers, then one more.
    in_valid = 1'b1; din0 = 18'd1024; din1 = 16'd1024; in_tag = 7'd11;
    sent = 0;
    cyc  = 0;
    while (sent < 65535 && cyc < 70000) begin
      applyStimulus(acc);
      if (acc) sent++;
      cyc++;
    end
    checkVal("sat_sent", sent, 65535);
    in_valid = 1'b0;
    repeat (4) applyStimulus(acc);
    checkVal("sat_full", n_pass, 16'hFFFF);
    sendPeek(18'd1024, 16'd1024, 7'd12);
    applyStimulus(acc);
    checkVal("sat_hold", n_pass, 16'hFFFF);

    // Clear coinciding with a transfer: clear wins.
    sendPeek(18'd1024, 16'd1024, 7'd13);
    checkVal("clr_pending", out_valid, 1'b1);
    cnt_clr = 1'b1;
    applyStimulus(acc);
    cnt_clr = 1'b0;
    checkVal("clr_n_pass", n_pass, 16'd0);
    checkVal("clr_n_fail", n_fail, 16'd0);
    repeat (3) applyStimulus(acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
